// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared FSM encoding and fixed-point helpers for the layer sequencer
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_START   = 3'd2,
    ST_ARM     = 3'd3,
    ST_WAIT    = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Left shift into the wider format, clamping to the all-ones code of out_width.
  function automatic logic [31:0] fixed_convert(input logic [31:0] value, input int shift,
                                                input int out_width);
    logic [63:0] w_shifted;
    logic [63:0] w_max;
    w_shifted = {32'd0, value} << shift;
    w_max     = (64'd1 << out_width) - 64'd1;
    if (w_shifted > w_max) return w_max[31:0];
    return w_shifted[31:0];
  endfunction

endpackage

// File: rtl/fixed_requantize.sv
// rtl/fixed_requantize.sv - masked, shifted, saturating lane converter from neuron outputs to layer inputs
module fixed_requantize
  import nn_pkg::*;
#(
  parameter int NUM_NEURON     = 6,
  parameter int NUM_INPUTS     = 5,
  parameter int INPUT_SIZE     = 9,
  parameter int INPUT_FRACTION = 8,
  parameter int OUTPUT_SIZE    = 10,
  parameter int FRACTION_BITS  = 6
) (
  input  logic [NUM_NEURON*OUTPUT_SIZE-1:0] i_values,
  input  logic [NUM_NEURON-1:0]             i_mask,
  output logic [NUM_INPUTS*INPUT_SIZE-1:0]  o_data
);

  localparam int SHIFT = INPUT_FRACTION - FRACTION_BITS;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    if (i < NUM_NEURON) begin : g_map
      logic [31:0] w_conv;
      logic        w_unused_hi;
      assign w_conv      = fixed_convert(32'(i_values[i*OUTPUT_SIZE +: OUTPUT_SIZE]), SHIFT, INPUT_SIZE);
      assign w_unused_hi = ^w_conv[31:INPUT_SIZE];
      assign o_data[i*INPUT_SIZE +: INPUT_SIZE] = i_mask[i] ? w_conv[INPUT_SIZE-1:0] : '0;
    end else begin : g_zero
      assign o_data[i*INPUT_SIZE +: INPUT_SIZE] = '0;
    end
  end

  // Neurons beyond the input slots have nowhere to go in the next pass.
  for (genvar j = NUM_INPUTS; j < NUM_NEURON; j++) begin : g_drop
    logic w_unused_drop;
    assign w_unused_drop = ^{i_values[j*OUTPUT_SIZE +: OUTPUT_SIZE], i_mask[j]};
  end

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - runs one multiplexed layer through NUM_LAYERS passes per sample
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_LAYERS     = 3,
  parameter int NUM_NEURON     = 6,
  parameter int NUM_INPUTS     = 5,
  parameter int INPUT_SIZE     = 9,
  parameter int INPUT_FRACTION = 8,
  parameter int OUTPUT_SIZE    = 10,
  parameter int FRACTION_BITS  = 6,
  parameter int TIMEOUT        = 1024,
  localparam int ADDR_W        = (clog2(NUM_LAYERS) > 0) ? clog2(NUM_LAYERS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_INPUTS*INPUT_SIZE-1:0]  in_data,
  input  logic [NUM_LAYERS*NUM_NEURON-1:0]  layer_active,
  output logic [ADDR_W-1:0]                 rom_addr,
  output logic                              layer_start,
  output logic [NUM_NEURON-1:0]             layer_active_o,
  output logic [NUM_INPUTS*INPUT_SIZE-1:0]  layer_inputs,
  input  logic [NUM_NEURON*OUTPUT_SIZE-1:0] layer_values,
  input  logic [NUM_NEURON-1:0]             layer_valid,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_NEURON*OUTPUT_SIZE-1:0] out_data,
  output logic                              error
);

  localparam int WD_W = (clog2(TIMEOUT) > 0) ? clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PASS_LAST = ADDR_W'(NUM_LAYERS - 1);

  state_t                          r_state;
  logic [ADDR_W-1:0]               r_pass;
  logic [WD_W-1:0]                 r_wdog;
  logic [NUM_NEURON-1:0]           r_mask;

  logic                            w_done;
  logic [ADDR_W-1:0]               w_pass_nxt;
  logic [NUM_NEURON-1:0]           w_mask_nxt;
  logic [NUM_INPUTS*INPUT_SIZE-1:0] w_next_inputs;

  assign rom_addr       = r_pass;
  assign layer_active_o = r_mask;

  // Masked-off neurons count as already valid.
  assign w_done     = &(layer_valid | ~r_mask);
  assign w_pass_nxt = r_pass + 1'b1;
  assign w_mask_nxt = layer_active[32'(w_pass_nxt)*NUM_NEURON +: NUM_NEURON];

  fixed_requantize #(
    .NUM_NEURON    (NUM_NEURON),
    .NUM_INPUTS    (NUM_INPUTS),
    .INPUT_SIZE    (INPUT_SIZE),
    .INPUT_FRACTION(INPUT_FRACTION),
    .OUTPUT_SIZE   (OUTPUT_SIZE),
    .FRACTION_BITS (FRACTION_BITS)
  ) u_requant (
    .i_values(layer_values),
    .i_mask  (r_mask),
    .o_data  (w_next_inputs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pass       <= '0;
      r_wdog       <= '0;
      r_mask       <= '0;
      in_ready     <= 1'b1;
      layer_start  <= 1'b0;
      layer_inputs <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      error        <= 1'b0;
    end else begin
      layer_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            layer_inputs <= in_data;
            r_pass       <= '0;
            r_mask       <= layer_active[NUM_NEURON-1:0];
            in_ready     <= 1'b0;
            r_state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          layer_start <= 1'b1;
          r_state     <= ST_START;
        end
        ST_START: r_state <= ST_ARM;
        // Valids left over from the previous pass may still be high here.
        ST_ARM: begin
          r_wdog  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_done) begin
            r_state <= ST_CAPTURE;
          end else if (r_wdog == WD_LAST) begin
            error    <= 1'b1;
            in_ready <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (r_pass != PASS_LAST) begin
            layer_inputs <= w_next_inputs;
            r_pass       <= w_pass_nxt;
            r_mask       <= w_mask_nxt;
            r_state      <= ST_FETCH;
          end else begin
            out_data  <= layer_values;
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
